// File: rtl/feature_quantizer_packer.sv
// feature_quantizer_packer: quantizes a stream of signed features against
// per-feature programmable thresholds and packs the codes into one vector
// for the layer0 input bus.
//  clk, rst_n                        clock, async active-low reset
//  cfg_we/cfg_addr/cfg_data          threshold write port (index = feature*NT + k)
//  s_valid/s_ready/s_data/s_last     raw feature stream, one feature per beat
//  m_valid/m_ready/m_data/m_err      packed vector stream; m_err flags a bad sample length
module feature_quantizer_packer #(
  parameter  int unsigned NUM_FEATURES = 8,
  parameter  int unsigned FEAT_WIDTH   = 16,
  parameter  int unsigned IN_BITS      = 2,
  localparam int unsigned OUT_WIDTH    = NUM_FEATURES * IN_BITS,
  localparam int unsigned ADDR_W       = $clog2(NUM_FEATURES * (2**IN_BITS - 1))
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [FEAT_WIDTH-1:0] cfg_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [FEAT_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic                  m_err
);

  localparam int unsigned NT    = 2**IN_BITS - 1;
  localparam int unsigned CNT_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic signed [FEAT_WIDTH-1:0]  thr_q [NUM_FEATURES][NT];
  logic [OUT_WIDTH-1:0]          asm_q;
  logic                          asm_err_q;
  logic                          asm_disc_q;
  logic [CNT_W-1:0]              cnt_q;

  logic [IN_BITS-1:0]            code_c;
  logic [OUT_WIDTH-1:0]          asm_new_c;
  logic                          accept_c;
  logic                          last_slot_c;
  logic                          out_free_c;
  logic                          close_c;
  logic                          close_err_c;
  logic                          drain_load_c;

  // Threshold table; every valid index is decoded explicitly so out-of-range writes fall through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < NUM_FEATURES; f++)
        for (int k = 0; k < NT; k++)
          thr_q[f][k] <= {1'b0, {(FEAT_WIDTH-1){1'b1}}};
    end else if (cfg_we) begin
      for (int f = 0; f < NUM_FEATURES; f++)
        for (int k = 0; k < NT; k++)
          if (cfg_addr == ADDR_W'(f * NT + k))
            thr_q[f][k] <= cfg_data;
    end
  end

  // Code = number of thresholds of the current feature that the input meets or exceeds.
  always_comb begin
    code_c = '0;
    for (int k = 0; k < NT; k++)
      if ($signed(s_data) >= thr_q[cnt_q][k])
        code_c = code_c + IN_BITS'(1);
  end

  // Assembly register with the current feature's field replaced.
  always_comb begin
    asm_new_c = asm_q;
    for (int i = 0; i < NUM_FEATURES; i++)
      if (cnt_q == CNT_W'(i))
        asm_new_c[i*IN_BITS +: IN_BITS] = code_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // Next state and datapath controls.
  always_comb begin
    state_d      = state_q;
    close_c      = 1'b0;
    drain_load_c = 1'b0;
    accept_c     = s_valid && s_ready;
    last_slot_c  = (cnt_q == CNT_W'(NUM_FEATURES - 1));
    out_free_c   = !m_valid || m_ready;
    close_err_c  = !(s_last && last_slot_c);
    unique case (state_q)
      COLLECT: begin
        if (accept_c && (s_last || last_slot_c)) begin
          close_c = 1'b1;
          if (!out_free_c)  state_d = WAIT;
          else if (s_last)  state_d = COLLECT;
          else              state_d = DISCARD;
        end
      end
      WAIT: begin
        if (m_valid && m_ready) begin
          drain_load_c = 1'b1;
          state_d      = asm_disc_q ? DISCARD : COLLECT;
        end
      end
      DISCARD: begin
        if (accept_c && s_last) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  // Assembly, output register and input ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_err      <= 1'b0;
      asm_q      <= '0;
      asm_err_q  <= 1'b0;
      asm_disc_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s_ready <= (state_d != WAIT);
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (close_c) begin
        cnt_q <= '0;
        if (out_free_c) begin
          m_valid <= 1'b1;
          m_data  <= asm_new_c;
          m_err   <= close_err_c;
          asm_q   <= '0;
        end else begin
          // Output busy: park the completed sample until the consumer drains.
          asm_q      <= asm_new_c;
          asm_err_q  <= close_err_c;
          asm_disc_q <= !s_last;
        end
      end else if (drain_load_c) begin
        m_valid <= 1'b1;
        m_data  <= asm_q;
        m_err   <= asm_err_q;
        asm_q   <= '0;
      end else if (accept_c && state_q == COLLECT) begin
        asm_q <= asm_new_c;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_feature_quantizer_packer.sv
// Bench for feature_quantizer_packer: table of samples plus hand sequences for
// back-pressure, config timing and mid-sample reset; outputs checked via a scoreboard.
module tb_feature_quantizer_packer;

  localparam int unsigned NF = 8;
  localparam int unsigned FW = 16;
  localparam int unsigned IB = 2;
  localparam int unsigned OW = NF * IB;
  localparam int unsigned AW = 5;
  localparam int NV = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [FW-1:0] cfg_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [FW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [OW-1:0] m_data;
  logic          m_err;

  always #5 clk = ~clk;

  feature_quantizer_packer dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err)
  );

  typedef struct packed {
    logic [9:0][FW-1:0] beats;
    logic [7:0]         n;
    logic [OW-1:0]      exp_data;
    logic               exp_err;
  } vec_t;

  typedef struct packed {
    logic [OW-1:0] d;
    logic          e;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(int n, logic [OW-1:0] d, logic e,
                              int b0, int b1, int b2, int b3, int b4,
                              int b5, int b6, int b7, int b8, int b9);
    vec_t v;
    v.n = 8'(n); v.exp_data = d; v.exp_err = e;
    v.beats[0] = FW'(b0); v.beats[1] = FW'(b1); v.beats[2] = FW'(b2);
    v.beats[3] = FW'(b3); v.beats[4] = FW'(b4); v.beats[5] = FW'(b5);
    v.beats[6] = FW'(b6); v.beats[7] = FW'(b7); v.beats[8] = FW'(b8);
    v.beats[9] = FW'(b9);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_beat(input logic [FW-1:0] d, input logic last);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!s_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!s_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL s_ready_timeout: got 0 expected 1 (t=%0t)", $time);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = FW'(data);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain_wait();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: a handshake happens at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output: got %h expected none", m_data);
      end else begin
        e = sb.pop_front();
        check("out_data", 32'(m_data), 32'(e.d));
        check("out_err", 32'(m_err), 32'(e.e));
      end
    end
  end

  initial begin
    vecs[0] = mk(8,  16'hA7E4, 1'b0, -20, -10, 5, 20, 100, -1, 0, 19, 0, 0);
    vecs[1] = mk(3,  16'h003F, 1'b1, 100, 100, 100, 0, 0, 0, 0, 0, 0, 0);
    vecs[2] = mk(10, 16'hA7E4, 1'b1, -20, -10, 5, 20, 100, -1, 0, 19, 7, 7);
    vecs[3] = mk(8,  16'hFFFF, 1'b0, 20, 20, 20, 20, 20, 20, 20, 20, 0, 0);
    vecs[4] = mk(8,  16'h0000, 1'b0, -11, -11, -11, -11, -11, -11, -11, -11, 0, 0);
    vecs[5] = mk(1,  16'h0002, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6] = mk(1,  16'h0003, 1'b1, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7] = mk(8,  16'h3636, 1'b0, 0, -10, 20, -11, 0, -10, 20, -11, 0, 0);
    vecs[8] = mk(7,  16'h3FFF, 1'b1, 20, 20, 20, 20, 20, 20, 20, 0, 0, 0);

    // Reset state
    #12;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_err", 32'(m_err), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    check("s_ready_after_release", 32'(s_ready), 32'd1);

    for (int f = 0; f < int'(NF); f++) begin
      cfg_write(f*3 + 0, -10);
      cfg_write(f*3 + 1, 0);
      cfg_write(f*3 + 2, 20);
    end
    cfg_write(24, 32767);

    // Table: m_ready held high, samples back-to-back
    for (int v = 0; v < NV; v++) begin
      int n;
      int close_idx;
      n = int'(vecs[v].n);
      close_idx = (n - 1 < 7) ? n - 1 : 7;
      sb.push_back({vecs[v].exp_data, vecs[v].exp_err});
      for (int i = 0; i < n; i++) begin
        send_beat(vecs[v].beats[i], i == n - 1);
        if (i == close_idx) check($sformatf("latency_v%0d", v), 32'(m_valid), 32'd1);
      end
    end
    drain_wait();

    // Back-pressure: two samples, second parks in WAIT
    m_ready = 1'b0;
    sb.push_back({16'hA7E4, 1'b0});
    for (int i = 0; i < 8; i++) send_beat(vecs[0].beats[i], i == 7);
    check("bp_first_valid", 32'(m_valid), 32'd1);
    sb.push_back({16'h3636, 1'b0});
    for (int i = 0; i < 8; i++) send_beat(vecs[7].beats[i], i == 7);
    check("bp_s_ready_low", 32'(s_ready), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("bp_hold_data", 32'(m_data), 32'h0000A7E4);
    check("bp_hold_err", 32'(m_err), 32'd0);
    check("bp_hold_valid", 32'(m_valid), 32'd1);
    check("bp_still_stalled", 32'(s_ready), 32'd0);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check("bp_second_valid", 32'(m_valid), 32'd1);
    check("bp_second_data", 32'(m_data), 32'h00003636);
    check("bp_s_ready_back", 32'(s_ready), 32'd1);
    m_ready = 1'b1;
    drain_wait();

    // Config write mid-sample takes effect on the next accepted beat
    sb.push_back({16'hAAAA, 1'b0});
    for (int i = 0; i < 5; i++) send_beat(16'd0, 1'b0);
    cfg_write(15, 50);
    send_beat(16'd30, 1'b0);
    send_beat(16'd0, 1'b0);
    send_beat(16'd0, 1'b1);
    drain_wait();

    // Reset mid-sample with a held output vector
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(vecs[0].beats[i], i == 7);
    check("pre_reset_valid", 32'(m_valid), 32'd1);
    for (int i = 0; i < 4; i++) send_beat(16'd5, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(m_valid), 32'd0);
    check("async_rst_data", 32'(m_data), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b1;
    sb.push_back({16'h300C, 1'b0});
    send_beat(16'd0, 1'b0);
    send_beat(16'h7FFF, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(16'd0, 1'b0);
    send_beat(16'h7FFF, 1'b0);
    send_beat(16'd0, 1'b1);
    drain_wait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
